cache_arbiter: RTL

Round-robin arbiter and sequencer that shares the single-port read cache (`cache_no_mode` style: address-in, busy `response`, data `out`) among NREQ requesters. It serialises requests, holds the cache address stable for a whole transaction, waits out the cache's busy phase, and returns the data and a one-cycle done pulse to the winning requester. Sits between the requesting units and the cache; the cache and RAM are unchanged.

---
 rtl/cache_arbiter_pkg.sv | 19 +
 rtl/cache_arbiter_rr_picker.sv | 29 ++
 rtl/cache_arbiter.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/cache_arbiter_pkg.sv
// Shared definitions for the cache arbiter: FSM state encoding and
// default parameter values used by the RTL and its testbench.
package cache_arbiter_pkg;

    localparam int NREQ_DEF      = 4;
    localparam int ADDR_W_DEF    = 32;
    localparam int DATA_W_DEF    = 32;
    localparam int RAM_DEPTH_DEF = 4096;
    localparam int TIMEOUT_DEF   = 255;
    localparam int CNT_W         = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/cache_arbiter_rr_picker.sv
// Combinational round-robin picker: scans requesters starting one past
// the last winner and returns the first one asserting req.
module rr_picker #(
    parameter int NREQ  = 4,
    parameter int PTR_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [PTR_W-1:0] winner,
    output logic             any_req
);

    // Scan from farthest to nearest so the nearest requester after ptr overrides.
    always_comb begin
        logic [PTR_W:0]   sum_v;
        logic [PTR_W-1:0] idx_v;
        winner  = '0;
        any_req = |req;
        sum_v   = '0;
        idx_v   = '0;
        for (int k = NREQ; k >= 1; k--) begin
            sum_v  = {1'b0, ptr} + (PTR_W+1)'(k);
            idx_v  = (sum_v >= (PTR_W+1)'(NREQ)) ? PTR_W'(sum_v - (PTR_W+1)'(NREQ))
                                                 : PTR_W'(sum_v);
            winner = req[idx_v] ? idx_v : winner;
        end
    end

endmodule

// File: rtl/cache_arbiter.sv
// Round-robin arbiter/sequencer in front of a single-port read cache.
// Serialises requests, holds the cache address for a whole transaction,
// waits out the busy phase (with timeout) and returns data plus a
// one-cycle done pulse. An unchanged address is served from the last
// captured data because the cache would not restart on it.
module cache_arbiter
    import cache_arbiter_pkg::*;
#(
    parameter int NREQ      = NREQ_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int RAM_DEPTH = RAM_DEPTH_DEF,
    parameter int TIMEOUT   = TIMEOUT_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*ADDR_W-1:0] addr,
    output logic [NREQ-1:0]        done,
    output logic [DATA_W-1:0]      rdata,
    output logic                   err,
    output logic [ADDR_W-1:0]      mem_addr,
    input  logic                   mem_busy,
    input  logic [DATA_W-1:0]      mem_data
);

    localparam int PTR_W = $clog2(NREQ);
    localparam logic [ADDR_W-1:0] ADDR_MASK = ADDR_W'(RAM_DEPTH - 1);

    arb_state_t         state_r,      state_nxt_s;
    logic [PTR_W-1:0]   ptr_r,        ptr_nxt_s;
    logic [PTR_W-1:0]   sel_r,        sel_nxt_s;
    logic [CNT_W-1:0]   cnt_r,        cnt_nxt_s;
    logic               last_valid_r, last_valid_nxt_s;
    logic [NREQ-1:0]    done_r,       done_nxt_s;
    logic [DATA_W-1:0]  rdata_r,      rdata_nxt_s;
    logic               err_r,        err_nxt_s;
    logic [ADDR_W-1:0]  mem_addr_r,   mem_addr_nxt_s;

    logic [PTR_W-1:0]   winner_s;
    logic               any_req_s;
    logic [ADDR_W-1:0]  win_addr_s;
    logic [ADDR_W-1:0]  wrapped_s;
    logic               bypass_s;
    logic [NREQ-1:0]    win_onehot_s;
    logic [NREQ-1:0]    sel_onehot_s;

    rr_picker #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_picker (
        .req     (req),
        .ptr     (ptr_r),
        .winner  (winner_s),
        .any_req (any_req_s)
    );

    // Select the winner's address, wrap it into RAM range and detect a repeat.
    always_comb begin
        win_addr_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            win_addr_s = (PTR_W'(i) == winner_s) ? addr[i*ADDR_W +: ADDR_W] : win_addr_s;
        end
        wrapped_s    = win_addr_s & ADDR_MASK;
        bypass_s     = last_valid_r && (wrapped_s == mem_addr_r);
        win_onehot_s = {{(NREQ-1){1'b0}}, 1'b1} << winner_s;
        sel_onehot_s = {{(NREQ-1){1'b0}}, 1'b1} << sel_r;
    end

    // Next-state and next-output logic; done and err default low so each lasts one cycle.
    always_comb begin
        state_nxt_s      = state_r;
        ptr_nxt_s        = ptr_r;
        sel_nxt_s        = sel_r;
        cnt_nxt_s        = cnt_r;
        last_valid_nxt_s = last_valid_r;
        done_nxt_s       = '0;
        rdata_nxt_s      = rdata_r;
        err_nxt_s        = 1'b0;
        mem_addr_nxt_s   = mem_addr_r;
        case (state_r)
            ST_IDLE: begin
                if (any_req_s) begin
                    ptr_nxt_s = winner_s;
                    sel_nxt_s = winner_s;
                    if (bypass_s) begin
                        // rdata still holds the data of this address
                        done_nxt_s  = win_onehot_s;
                        state_nxt_s = ST_DONE;
                    end else begin
                        mem_addr_nxt_s = wrapped_s;
                        cnt_nxt_s      = '0;
                        state_nxt_s    = ST_ISSUE;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                // cache reacts on the falling edge, busy is not meaningful yet
                state_nxt_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (!mem_busy) begin
                    rdata_nxt_s      = mem_data;
                    last_valid_nxt_s = 1'b1;
                    done_nxt_s       = sel_onehot_s;
                    state_nxt_s      = ST_DONE;
                end else if (cnt_r == CNT_W'(TIMEOUT)) begin
                    rdata_nxt_s      = '0;
                    err_nxt_s        = 1'b1;
                    last_valid_nxt_s = 1'b0;
                    done_nxt_s       = sel_onehot_s;
                    state_nxt_s      = ST_DONE;
                end else begin
                    cnt_nxt_s = cnt_r + 8'd1;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any transaction without a done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            ptr_r        <= PTR_W'(NREQ - 1);
            sel_r        <= '0;
            cnt_r        <= '0;
            last_valid_r <= 1'b0;
            done_r       <= '0;
            rdata_r      <= '0;
            err_r        <= 1'b0;
            mem_addr_r   <= '0;
        end else begin
            state_r      <= state_nxt_s;
            ptr_r        <= ptr_nxt_s;
            sel_r        <= sel_nxt_s;
            cnt_r        <= cnt_nxt_s;
            last_valid_r <= last_valid_nxt_s;
            done_r       <= done_nxt_s;
            rdata_r      <= rdata_nxt_s;
            err_r        <= err_nxt_s;
            mem_addr_r   <= mem_addr_nxt_s;
        end
    end

    assign done     = done_r;
    assign rdata    = rdata_r;
    assign err      = err_r;
    assign mem_addr = mem_addr_r;

endmodule
